// File: rtl/cnn_pixel_streamer_if.sv
// rtl/cnn_pixel_streamer_if.sv - host/stream signal bundle for cnn_pixel_streamer
// Host -> streamer : wr_en, wr_data, clear, start, pause
// Streamer -> host : pixel_data, pixel_en, frame_ready, busy, done
// Modports: master (host / CNN side), slave (streamer side)
interface cnn_pixel_streamer_if #(
  parameter int PIXEL_WIDTH = 24
) ();
  logic                   wr_en;
  logic [PIXEL_WIDTH-1:0] wr_data;
  logic                   clear;
  logic                   start;
  logic                   pause;
  logic [PIXEL_WIDTH-1:0] pixel_data;
  logic                   pixel_en;
  logic                   frame_ready;
  logic                   busy;
  logic                   done;

  modport master (
    output wr_en, wr_data, clear, start, pause,
    input  pixel_data, pixel_en, frame_ready, busy, done
  );

  modport slave (
    input  wr_en, wr_data, clear, start, pause,
    output pixel_data, pixel_en, frame_ready, busy, done
  );
endinterface

// File: rtl/cnn_pixel_streamer.sv
// rtl/cnn_pixel_streamer.sv - frame buffer that replays a stored image as a CNN pixel stream
// clk  : rising-edge clock
// rst  : asynchronous active-high reset
// bus  : cnn_pixel_streamer_if.slave (host writes, start/pause/clear, pixel_data/pixel_en out,
//        frame_ready/busy/done status)
// Optional macro CNN_STREAMER_BLANKING_EN: ROW_GAP idle cycles after every row except the last.
module cnn_pixel_streamer #(
  parameter int PIXEL_WIDTH = 24,
  parameter int IMAGE_SIZE  = 64,
  parameter int ROW_GAP     = 4
) (
  input logic                 clk,
  input logic                 rst,
  cnn_pixel_streamer_if.slave bus
);
  localparam int N  = IMAGE_SIZE * IMAGE_SIZE;
  localparam int AW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADING,
    S_READY,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [PIXEL_WIDTH-1:0] r_mem [N];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [PIXEL_WIDTH-1:0] r_pixel_data;
  logic                   r_pixel_en;
  logic                   w_wr;
  logic                   w_last_wr;
  logic                   w_rd;
  logic                   w_last_rd;
  logic                   w_gap;
  logic                   w_start_stream;
  logic                   w_frame_ready;
  logic                   w_busy;
  logic                   w_done;

  // Writes are only accepted while a frame is being loaded; clear discards a coincident write.
  assign w_wr      = bus.wr_en && !bus.clear && (r_state == S_IDLE || r_state == S_LOADING);
  assign w_last_wr = w_wr && (r_wr_ptr == AW'(N - 1));

  // One buffer read per unpaused, non-blanking STREAM cycle; the word appears a cycle later.
  assign w_rd      = (r_state == S_STREAM) && !bus.pause && !w_gap && !bus.clear;
  assign w_last_rd = w_rd && (r_rd_ptr == AW'(N - 1));

  assign w_start_stream = (r_state == S_READY) && bus.start && !bus.clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_frame_ready = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE:    if (w_wr) w_next = S_LOADING;
      S_LOADING: if (w_last_wr) w_next = S_READY;
      S_READY: begin
        w_frame_ready = 1'b1;
        if (bus.start) w_next = S_STREAM;
      end
      S_STREAM: begin
        w_busy = 1'b1;
        if (w_last_rd) w_next = S_DONE;
      end
      S_DONE: begin
        // The final pixel is on the bus during this cycle.
        w_done = 1'b1;
        w_next = S_READY;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.clear) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_pixel_data <= '0;
      r_pixel_en   <= 1'b0;
    end else if (bus.clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_pixel_data <= '0;
      r_pixel_en   <= 1'b0;
    end else begin
      r_pixel_en <= w_rd;
      if (w_wr) r_wr_ptr <= w_last_wr ? '0 : r_wr_ptr + AW'(1);
      if (w_start_stream) begin
        r_rd_ptr <= '0;
      end else if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_rd) r_pixel_data <= r_mem[r_rd_ptr];
    end
  end

  // Buffer contents are not reset; they are only meaningful once a full frame is loaded.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.wr_data;
  end

`ifdef CNN_STREAMER_BLANKING_EN
  localparam int CW = $clog2(IMAGE_SIZE);
  localparam int GW = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;

  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic [GW-1:0] r_gap;

  assign w_gap = (r_gap != '0);

  // The gap counts down every cycle regardless of pause so that pausing never stretches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_gap <= '0;
    end else if (bus.clear || w_start_stream) begin
      r_col <= '0;
      r_row <= '0;
      r_gap <= '0;
    end else if (w_rd) begin
      if (r_col == CW'(IMAGE_SIZE - 1)) begin
        r_col <= '0;
        r_row <= r_row + CW'(1);
        if (r_row != CW'(IMAGE_SIZE - 1)) r_gap <= GW'(ROW_GAP);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end else if (w_gap) begin
      r_gap <= r_gap - GW'(1);
    end
  end
`else
  logic w_unused_row_gap;
  assign w_unused_row_gap = ^ROW_GAP;
  assign w_gap            = 1'b0;
`endif

  assign bus.pixel_data  = r_pixel_data;
  assign bus.pixel_en    = r_pixel_en;
  assign bus.frame_ready = w_frame_ready;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// tb/tb_cnn_pixel_streamer.sv - self-checking bench for cnn_pixel_streamer
module tb_cnn_pixel_streamer;
  localparam int PW      = 24;
  localparam int IS      = 64;
  localparam int ROW_GAP = 4;
  localparam int N       = IS * IS;
`ifdef CNN_STREAMER_BLANKING_EN
  localparam int BLANK = (IS - 1) * ROW_GAP;
`else
  localparam int BLANK = 0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;

  logic [PW-1:0] frame [N];
  logic [PW-1:0] model_data;

  cnn_pixel_streamer_if #(.PIXEL_WIDTH(PW)) u_if ();

  cnn_pixel_streamer #(
    .PIXEL_WIDTH(PW),
    .IMAGE_SIZE (IS),
    .ROW_GAP    (ROW_GAP)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pixel_en"},    32'(u_if.pixel_en),    32'(0));
    check({tag, "_pixel_data"},  32'(u_if.pixel_data),  32'(0));
    check({tag, "_frame_ready"}, 32'(u_if.frame_ready), 32'(0));
    check({tag, "_busy"},        32'(u_if.busy),        32'(0));
    check({tag, "_done"},        32'(u_if.done),        32'(0));
  endtask

  // Load a whole frame; optionally poke start mid-load and on the final write (both ignored).
  task automatic load_frame(input bit rnd, input bit start_noise);
    for (int i = 0; i < N; i++) begin
      frame[i]      = rnd ? PW'($urandom) : PW'(i);
      u_if.wr_en    = 1'b1;
      u_if.wr_data  = frame[i];
      u_if.start    = start_noise && (i == 100 || i == N - 1);
      step();
      if (start_noise && i == 100) check("load_busy_mid", 32'(u_if.busy), 32'(0));
      if (i == N - 2) check("load_not_ready_early", 32'(u_if.frame_ready), 32'(0));
    end
    u_if.wr_en = 1'b0;
    u_if.start = 1'b0;
    check("load_frame_ready", 32'(u_if.frame_ready), 32'(1));
    check("load_busy",        32'(u_if.busy),        32'(0));
    step();
    check("load_ready_hold",  32'(u_if.frame_ready), 32'(1));
    check("load_no_stream",   32'(u_if.busy),        32'(0));
    check("load_no_pixel",    32'(u_if.pixel_en),    32'(0));
  endtask

  // Stream the stored frame. The model: every STREAM cycle with pause low (and no row gap)
  // delivers the next frame pixel on the following cycle.
  task automatic stream_frame(input string tag, input int p_lo, input int p_hi, input bit rnd,
                              input bit p_start, input int abort_at, input int exp_lows);
    int issued, seen, lows, pulses, c, gap_left;
    bit exp_en, p, rd;
    issued = 0; seen = 0; lows = 0; pulses = 0; c = 0; gap_left = 0; exp_en = 1'b0;
    u_if.start = 1'b1;
    u_if.pause = p_start;
    step();
    u_if.start = 1'b0;
    check({tag, "_busy_t1"}, 32'(u_if.busy), 32'(1));
    while (seen < N && c < 4 * N) begin
      check({tag, "_pixel_en"}, 32'(u_if.pixel_en), 32'(exp_en));
      if (u_if.pixel_en) pulses++;
      else if (seen > 0) lows++;
      if (exp_en) begin
        model_data = frame[seen];
        check({tag, "_done"}, 32'(u_if.done), 32'(seen == N - 1));
        seen++;
      end else begin
        check({tag, "_done_low"}, 32'(u_if.done), 32'(0));
      end
      check({tag, "_pixel_data"}, 32'(u_if.pixel_data), 32'(model_data));
      check({tag, "_busy"}, 32'(u_if.busy), 32'(seen != N));
      if (abort_at >= 0 && seen == abort_at + 1) begin
        rst = 1'b1;
        #1;
        check_idle_outputs({tag, "_async_rst"});
        model_data = '0;
        return;
      end
      if (seen == N) break;
      p            = rnd ? ($urandom_range(3) == 0) : (c >= p_lo && c <= p_hi);
      u_if.pause   = p;
      u_if.wr_en   = 1'($urandom_range(1));
      u_if.wr_data = PW'($urandom);
      rd = !p && gap_left == 0 && issued < N;
      if (gap_left > 0) gap_left--;
      if (rd) begin
`ifdef CNN_STREAMER_BLANKING_EN
        if (issued % IS == IS - 1 && issued != N - 1) gap_left = ROW_GAP;
`endif
        issued++;
      end
      exp_en = rd;
      step();
      c++;
    end
    u_if.pause = 1'b0;
    u_if.wr_en = 1'b0;
    check({tag, "_pulses"}, 32'(pulses), 32'(N));
    if (exp_lows >= 0) check({tag, "_low_cycles"}, 32'(lows), 32'(exp_lows));
    step();
    check({tag, "_after_ready"}, 32'(u_if.frame_ready), 32'(1));
    check({tag, "_after_en"},    32'(u_if.pixel_en),    32'(0));
    check({tag, "_after_done"},  32'(u_if.done),        32'(0));
  endtask

  initial begin
    n_vec        = 0;
    n_fail       = 0;
    model_data   = '0;
    rst          = 1'b1;
    u_if.wr_en   = 1'b0;
    u_if.wr_data = '0;
    u_if.clear   = 1'b0;
    u_if.start   = 1'b0;
    u_if.pause   = 1'b0;
    step();
    check_idle_outputs("reset");
    step();
    rst = 1'b0;
    step();
    check_idle_outputs("post_reset");

    load_frame(1'b0, 1'b1);
    stream_frame("basic", -1, -2, 1'b0, 1'b0, -1, BLANK);
    stream_frame("pause", 10, 14, 1'b0, 1'b0, -1, 5 + BLANK);
    stream_frame("replay_rnd", -1, -2, 1'b1, 1'b1, -1, -1);

    u_if.clear = 1'b1;
    step();
    u_if.clear = 1'b0;
    model_data = '0;
    check_idle_outputs("clear");
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("idle_start_no_en", 32'(u_if.pixel_en), 32'(0));
      check("idle_start_no_busy", 32'(u_if.busy), 32'(0));
      step();
    end

    u_if.wr_en   = 1'b1;
    u_if.wr_data = 24'hDEAD01;
    u_if.clear   = 1'b1;
    step();
    u_if.wr_en = 1'b0;
    u_if.clear = 1'b0;
    check("clear_wr_ready", 32'(u_if.frame_ready), 32'(0));
    load_frame(1'b1, 1'b0);
    stream_frame("abort", -1, -2, 1'b0, 1'b0, 1000, -1);
    step();
    check_idle_outputs("rst_hold");
    rst          = 1'b0;
    u_if.wr_en   = 1'b0;
    u_if.pause   = 1'b0;
    step();
    check_idle_outputs("rst_release");

    load_frame(1'b1, 1'b0);
    stream_frame("fresh", -1, -2, 1'b0, 1'b0, -1, BLANK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/cnn_pixel_streamer.md
Name: cnn_pixel_streamer

Overview:
- Source end of the CNN pixel stream. A host writes a full image into an internal frame buffer, one packed RGB pixel per write.
- On a start pulse, the block replays the image in raster order. It drives pixel_data / pixel_en, which are the data and clock-enable pair consumed by the CNN's convolutional input stage.
- It supports a downstream pause and signals frame completion, so the CNN top can be fed frame after frame.

Parameters:
- PIXEL_WIDTH, 24, packed pixel width (CHANNELS x 8 bits).
- IMAGE_SIZE, 64, image side length; buffer depth is IMAGE_SIZE*IMAGE_SIZE.
- ROW_GAP, 4, idle cycles inserted after each row. Used only when CNN_STREAMER_BLANKING_EN is defined.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  host pixel write strobe.
- wr_data  input  PIXEL_WIDTH  host pixel, raster order, R in bits [23:16].
- clear  input  1  discard the stored frame and return to IDLE.
- start  input  1  single-cycle request to stream the stored frame.
- pause  input  1  downstream hold; no pixel is issued while high.
- pixel_data  output  PIXEL_WIDTH  pixel to the CNN input_data.
- pixel_en  output  1  pixel valid; drives the CNN clk_en.
- frame_ready  output  1  a full frame is stored and the block is idle.
- busy  output  1  streaming in progress.
- done  output  1  single-cycle pulse after the last pixel is issued.

Behaviour:
- Reset: state IDLE; pixel_data=0, pixel_en=0, frame_ready=0, busy=0, done=0; wr_ptr=0, rd_ptr=0. Buffer contents are undefined. Reset mid-stream aborts immediately.
- Pointers: clog2(IMAGE_SIZE*IMAGE_SIZE) bits, 12 bits at default. Row and column counters: clog2(IMAGE_SIZE) bits each.
- States:
  - IDLE: the first wr_en writes mem[0] and moves to LOADING.
  - LOADING: each wr_en writes mem[wr_ptr] and increments wr_ptr. The write at wr_ptr = N-1 (N = IMAGE_SIZE^2) moves to READY and resets wr_ptr to 0.
  - READY: frame_ready=1. start moves to STREAM with rd_ptr=0. wr_en is ignored.
  - STREAM: busy=1. wr_en and start are ignored.
    - Each cycle with pause=0, the block reads mem[rd_ptr] and advances rd_ptr.
    - On the next cycle, pixel_data holds that word and pixel_en=1.
    - A cycle with pause=1 issues no read, so pixel_en is 0 on the following cycle. pixel_data holds its last value.
    - After issuing rd_ptr = N-1, the block moves to DONE.
  - DONE: lasts one cycle. It is the cycle in which pixel_en=1 for pixel N-1, with done=1 and busy=0 in the same cycle. Then the block returns to READY; the frame is retained, so start replays it.
- Latency: start in cycle t gives pixel_en=1 for pixel 0 in cycle t+2, with no pause. An unpaused frame issues exactly N pixel_en pulses in N consecutive cycles.
- pixel_en is never high outside STREAM/DONE.
- clear:
  - Has priority over every other input in all non-reset states.
  - In the next cycle: state IDLE, pointers 0, outputs 0.
  - clear in the same cycle as wr_en: the write is discarded.
- start in the same cycle as the final load write is ignored; start must be asserted in READY.
- pause in the same cycle as start: the transition to STREAM still occurs; the first read waits for pause=0.

Optional Feature:
- Macro: CNN_STREAMER_BLANKING_EN.
- Defined: after the read of the last column of each row (column counter = IMAGE_SIZE-1), the block inserts ROW_GAP cycles with no read, so pixel_en is low for ROW_GAP cycles between rows. Blanking is not inserted after the final row. Pause cycles during blanking do not extend the gap beyond ROW_GAP. Total unpaused frame length: N + (IMAGE_SIZE-1)*ROW_GAP cycles.
- Undefined: no blanking and no row counter logic; pixels are issued back-to-back.

Test Plan:
- Load and basic stream: reset, write 4096 pixels with value = index, pulse start -> 4096 consecutive pixel_en pulses with pixel_data 0x000000..0x000FFF in order; first pulse 2 cycles after start; done high with pixel 4095.
- Pause: hold pause high for cycles 10-14 of the stream -> pixel_en low for exactly 5 cycles; no pixel dropped or duplicated; total 4096 pulses.
- Replay and clear: after done, start again -> identical 4096-pixel sequence. Then pulse clear -> frame_ready=0; a start while in IDLE produces no pixel_en.
- Reset mid-stream: assert rst at pixel 1000 -> all outputs 0 asynchronously. After release, state IDLE; writes load a fresh frame starting at mem[0].
- Ignored inputs: wr_en during STREAM and start during LOADING -> no buffer corruption; the streamed data still matches the original frame.
- Blanking (macro defined, ROW_GAP=4): stream a frame -> pixel_en low for 4 cycles after pixels 63, 127, ..., 4031 and not after 4095; total stream length 4096 + 252 cycles.
